// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-only data-memory interface.
// Accepts one load/store request at a time and adds byte/halfword access:
// sign/zero extension on loads, read-modify-write for sub-word stores.
// Misaligned, illegal-funct3 and out-of-range requests complete with resp_err
// and make no memory access.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready                 request handshake (ready only in IDLE)
//   req_store, req_funct3               operation and access size/extension
//   req_addr, req_wdata                 byte address, right-aligned store data
//   resp_valid, resp_rdata, resp_err    one-cycle completion pulse + result
//   mem_address, mem_writeData          word address and merged write word
//   mem_memWrite, mem_memRead           strobes, decoded from the state register
//   mem_readData                        combinational read data from memory
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  output logic        mem_memRead,
  input  logic [31:0] mem_readData
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_store;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic        w_illegal;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_err;
  logic [4:0]  w_byte_shamt;
  logic [4:0]  w_half_shamt;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;
  logic [31:0] w_lane_mask;
  logic [31:0] w_lane_data;
  logic [31:0] w_merged;

  // Request checks on the live request inputs, used only at the accept edge.
  assign w_illegal      = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                          (req_funct3[2] && req_store);
  assign w_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_out_of_range = (req_addr >= 32'(MEM_BYTES));
  assign w_err          = w_illegal || w_misaligned || w_out_of_range;

  assign w_byte_shamt = {r_addr[1:0], 3'b000};
  assign w_half_shamt = {r_addr[1], 4'b0000};

  // Load lane extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_lane      = 32'h0;
    w_load_data = mem_readData;
    case (r_funct3)
      3'b000: begin
        w_lane      = mem_readData >> w_byte_shamt;
        w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      end
      3'b001: begin
        w_lane      = mem_readData >> w_half_shamt;
        w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      end
      3'b100: begin
        w_lane      = mem_readData >> w_byte_shamt;
        w_load_data = {24'h0, w_lane[7:0]};
      end
      3'b101: begin
        w_lane      = mem_readData >> w_half_shamt;
        w_load_data = {16'h0, w_lane[15:0]};
      end
      default: begin
        w_lane      = 32'h0;
        w_load_data = mem_readData;
      end
    endcase
  end

  // Sub-word store merge: replace one byte or halfword lane of the read word.
  always_comb begin
    if (r_funct3[0]) begin
      w_lane_mask = 32'h0000_FFFF << w_half_shamt;
      w_lane_data = {16'h0, r_wdata} << w_half_shamt;
    end else begin
      w_lane_mask = 32'h0000_00FF << w_byte_shamt;
      w_lane_data = {24'h0, r_wdata[7:0]} << w_byte_shamt;
    end
    w_merged = (mem_readData & ~w_lane_mask) | (w_lane_data & w_lane_mask);
  end

  // Request FSM; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'h0;
      r_wdata      <= 16'h0;
      r_funct3     <= 3'b000;
      r_store      <= 1'b0;
      r_mem_wdata  <= 32'h0;
      r_resp_rdata <= 32'h0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata[15:0];
            r_funct3 <= req_funct3;
            r_store  <= req_store;
            if (w_err) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
              r_state      <= S_RESP;
            end else if (req_store && (req_funct3 == 3'b010)) begin
              r_mem_wdata <= req_wdata;
              r_state     <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (r_store) begin
            r_mem_wdata <= w_merged;
            r_state     <= S_WR;
          end else begin
            r_resp_rdata <= w_load_data;
            r_resp_err   <= 1'b0;
            r_state      <= S_RESP;
          end
        end
        S_WR: begin
          r_resp_rdata <= 32'h0;
          r_resp_err   <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign resp_valid    = (r_state == S_RESP);
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign mem_address   = {r_addr[31:2], 2'b00};
  assign mem_writeData = r_mem_wdata;
  assign mem_memRead   = (r_state == S_RD);
  assign mem_memWrite  = (r_state == S_WR);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model plus a byte-array reference.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  logic [31:0] mem_words [1024];
  logic [7:0]  ref_mem   [4096];

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_readData(mem_readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on rising edge; counts strobes.
  assign mem_readData = mem_words[mem_address[11:2]];
  initial begin
    for (int i = 0; i < 1024; i++) mem_words[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
    forever begin
      @(posedge clk);
      if (mem_memRead) rd_cnt++;
      if (mem_memWrite) begin
        wr_cnt++;
        mem_words[mem_address[11:2]] = mem_writeData;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {ref_mem[b + 12'd3], ref_mem[b + 12'd2], ref_mem[b + 12'd1], ref_mem[b]};
  endfunction

  function automatic bit model_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit illegal;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (st && f3 >= 3'd4);
    if (illegal) return 1'b1;
    if ((a % acc_size(f3)) != 0) return 1'b1;
    return a >= 32'd4096;
  endfunction

  // Little-endian byte gather, then two's-complement sign extension for LB/LH.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [63:0] v;
    int unsigned sz;
    sz = acc_size(f3);
    v = 64'h0;
    for (int k = 0; k < int'(sz); k++)
      v = v | (64'(ref_mem[12'(a[11:0] + 12'(k))]) << (8 * k));
    if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int k = 0; k < int'(acc_size(f3)); k++)
      ref_mem[12'(a[11:0] + 12'(k))] = 8'(wd >> (8 * k));
  endtask

  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    bit          e;
    int          exp_lat, lat, rd0, wr0, exp_rd, exp_wr;
    logic [31:0] exp_data;
    e = model_err(st, f3, a);
    exp_data = (e || st) ? 32'h0 : model_load(f3, a);
    exp_lat  = e ? 1 : (!st ? 2 : (acc_size(f3) == 4 ? 2 : 3));
    exp_rd   = (e || (st && acc_size(f3) == 4)) ? 0 : 1;
    exp_wr   = (e || !st) ? 0 : 1;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_err", 32'(resp_err), 32'(e));
    chk("resp_rdata", resp_rdata, exp_data);
    @(posedge clk); #1;
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
    chk("mem_reads", 32'(rd_cnt - rd0), 32'(exp_rd));
    chk("mem_writes", 32'(wr_cnt - wr0), 32'(exp_wr));
    if (st && !e) begin
      model_store(f3, a, wd);
      chk("mem_word", mem_words[a[11:2]], ref_word(a));
    end
  endtask

  initial begin
    int n_resp, n_busy;
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    logic [2:0] f3_tab [8];
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};

    for (int i = 0; i < 4096; i++)
      ref_mem[i] = 8'((32'(i / 4) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F) >> (8 * (i % 4)));

    // Reset with a request presented: it must be ignored.
    rst_n = 1'b0; req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_writeData, 32'h0);
    chk("rst_strobes", 32'({mem_memRead, mem_memWrite}), 32'd0);
    @(negedge clk); req_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_access", 32'(rd_cnt + wr_cnt), 32'd0);
    chk("rst_word_kept", mem_words[16], ref_word(32'h40));

    // SW then LW.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    chk("sw_word", mem_words[4], 32'hDEAD_BEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_data", resp_rdata, 32'hDEAD_BEEF);

    // SB read-modify-write.
    do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344);
    do_req(1'b1, 3'b000, 32'h12, 32'h0000_00AB);
    chk("sb_word", mem_words[4], 32'h11AB_3344);

    // Load extension.
    do_req(1'b1, 3'b010, 32'h10, 32'h80FF_7F01);
    do_req(1'b0, 3'b000, 32'h13, 32'h0); chk("lb", resp_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'h13, 32'h0); chk("lbu", resp_rdata, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h12, 32'h0); chk("lh", resp_rdata, 32'hFFFF_80FF);
    do_req(1'b0, 3'b101, 32'h10, 32'h0); chk("lhu", resp_rdata, 32'h0000_7F01);

    // Error cases.
    do_req(1'b0, 3'b010, 32'h11, 32'h0);
    do_req(1'b1, 3'b001, 32'h13, 32'h1234);
    do_req(1'b0, 3'b011, 32'h10, 32'h0);
    do_req(1'b1, 3'b010, 32'h1000, 32'h5555_AAAA);
    do_req(1'b1, 3'b100, 32'h10, 32'h77);
    chk("err_word_kept", mem_words[4], 32'h80FF_7F01);

    // req_valid held high: LW issues once every three cycles.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    n_resp = 0; n_busy = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (!req_ready) n_busy++;
      if (resp_valid) begin
        n_resp++;
        chk("b2b_rdata", resp_rdata, 32'h80FF_7F01);
      end
    end
    @(negedge clk); req_valid = 1'b0;
    chk("b2b_resp_count", 32'(n_resp), 32'd3);
    chk("b2b_busy_cycles", 32'(n_busy), 32'd6);

    // Randomized requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      st = 1'($urandom);
      f3 = f3_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) a = 32'd4096 + $urandom_range(0, 255);
      else a = 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f3) - 1);
      do_req(st, f3, a, $urandom);
    end

    // Reset during WR: strobe drops at once and the word stays intact.
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = ~ref_word(32'h20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr_strobe", 32'(mem_memWrite), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_strobe_drop", 32'(mem_memWrite), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_mid_word", mem_words[8], ref_word(32'h20));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready2", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
